// File: rtl/xor_sched_pkg.sv
// rtl/xor_sched_pkg.sv - shared state encodings and helpers for xor_parity_scheduler
// Contents:
//   state_t  : scheduler FSM states (IDLE, SHIFT, DONE)
//   clog2()  : ceiling log2 used to size the index and bit-counter fields
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/parity_xor_stage.sv
// rtl/parity_xor_stage.sv - bit-serial XOR accumulate stage shared by all requesters
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data, clear accumulator and bit counter
//   shift       : fold sh[0] into the accumulator, shift right, count the bit
//   load_data   : word to be reduced
//   acc_next    : accumulator value including the bit currently at sh[0]
//   last        : the bit at sh[0] is the final bit of the word
module parity_xor_stage
  import xor_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             acc_next,
  output logic             last
);

  localparam int CW = clog2(WIDTH);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The single shared XOR cell.
  assign acc_next = acc_q ^ sh_q[0];
  assign last     = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    sh_d  = sh_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      acc_d = 1'b0;
      cnt_d = '0;
    end else if (shift) begin
      sh_d  = sh_q >> 1;
      acc_d = acc_next;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xor_parity_scheduler.sv
// rtl/xor_parity_scheduler.sv - arbitrates NREQ requesters onto one bit-serial parity stage
// Build option: XOR_SCHED_RR_EN selects round-robin arbitration; undefined gives fixed
// priority (lowest index wins) with no pointer register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : level request per requester
//   din         : flattened words, requester i at [i*WIDTH +: WIDTH]
//   gnt         : one-hot grant pulse on the capture cycle
//   busy        : high from capture until the end of the DONE cycle
//   done        : one-cycle completion pulse
//   done_id     : index of the completed requester, held until next done
//   parity      : XOR of the completed word, held until next done
module xor_parity_scheduler
  import xor_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    din,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [clog2(NREQ)-1:0]   done_id,
  output logic                     parity
);

  localparam int IW = clog2(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IW-1:0]   done_id_q, done_id_d;
  logic            parity_q, parity_d;
  logic [IW-1:0]   win_q, win_d;

  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_word;
  logic             load, shift, acc_next, last;

`ifdef XOR_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downward in distance from the pointer so the closest requester
  // (searching upward with wrap) is the last one assigned.
  always_comb begin
    int j;
    win_idx = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) win_idx = IW'(j);
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) win_idx = IW'(k);
    end
  end
`endif

  assign win_word = din[int'(win_idx)*WIDTH +: WIDTH];

  parity_xor_stage #(.WIDTH(WIDTH)) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .load_data(win_word),
    .acc_next (acc_next),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    parity_d  = parity_q;
    win_d     = win_q;
    load      = 1'b0;
    shift     = 1'b0;
`ifdef XOR_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          win_d   = win_idx;
          state_d = SHIFT;
`ifdef XOR_SCHED_RR_EN
          ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
`endif
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          // acc_next already folds in the final bit on this edge.
          parity_d  = acc_next;
          done_id_d = win_q;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      parity_q  <= 1'b0;
      win_q     <= '0;
`ifdef XOR_SCHED_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      parity_q  <= parity_d;
      win_q     <= win_d;
`ifdef XOR_SCHED_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign parity  = parity_q;

endmodule
